// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: round-robin share of one instruction-memory port between fetch and loader.
// Optional halt detection on fetched words is enabled by defining IMEM_ARB_HALT_DETECT_EN.
module imem_port_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 10
`ifdef IMEM_ARB_HALT_DETECT_EN
    , parameter logic [2:0] HALT_OPCODE = 3'b111
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic              ld_valid,
    output logic [DATA_W-1:0] ld_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              halted
);
    typedef enum logic {IDLE, ACCESS} state_t;
    state_t            state_q, state_d;
    logic              last_ld_q, last_ld_d, win_ld_q, win_ld_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, fdata_q, fdata_d, ldata_q, ldata_d;
    logic              we_q, we_d, fgnt_q, fgnt_d, lgnt_q, lgnt_d;
    logic              fvalid_q, fvalid_d, lvalid_q, lvalid_d, halted_q, halted_d;
    logic              fetch_elig, pick, pick_ld, acc;
    always_comb begin
        fetch_elig = fetch_req & ~halted_q;
        acc        = state_q == ACCESS;
        pick       = (state_q == IDLE) & (fetch_elig | ld_req);
        // Loader wins when it is alone or when fetch won the previous access.
        pick_ld    = ld_req & (~fetch_elig | ~last_ld_q);
        state_d    = pick ? ACCESS : IDLE;
        win_ld_d   = pick ? pick_ld : win_ld_q;
        addr_d     = pick ? (pick_ld ? ld_addr : fetch_addr) : addr_q;
        wdata_d    = (pick & pick_ld) ? ld_wdata : wdata_q;
        we_d       = pick & pick_ld & ld_we;
        fgnt_d     = pick & ~pick_ld;
        lgnt_d     = pick & pick_ld;
        fvalid_d   = acc & ~win_ld_q;
        lvalid_d   = acc & win_ld_q;
        fdata_d    = fvalid_d ? mem_rdata : fdata_q;
        ldata_d    = lvalid_d ? mem_rdata : ldata_q;
        last_ld_d  = acc ? win_ld_q : last_ld_q;
`ifdef IMEM_ARB_HALT_DETECT_EN
        halted_d   = (fvalid_d & (mem_rdata[DATA_W-1 -: 3] == HALT_OPCODE)) ? 1'b1 :
                     (acc & we_q) ? 1'b0 : halted_q;
`else
        halted_d   = 1'b0;
`endif
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            last_ld_q <= 1'b1;
            win_ld_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            fgnt_q    <= 1'b0;
            lgnt_q    <= 1'b0;
            fvalid_q  <= 1'b0;
            lvalid_q  <= 1'b0;
            fdata_q   <= '0;
            ldata_q   <= '0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_ld_q <= last_ld_d;
            win_ld_q  <= win_ld_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            fgnt_q    <= fgnt_d;
            lgnt_q    <= lgnt_d;
            fvalid_q  <= fvalid_d;
            lvalid_q  <= lvalid_d;
            fdata_q   <= fdata_d;
            ldata_q   <= ldata_d;
            halted_q  <= halted_d;
        end
    end
    assign fetch_gnt   = fgnt_q;
    assign fetch_valid = fvalid_q;
    assign fetch_data  = fdata_q;
    assign ld_gnt      = lgnt_q;
    assign ld_valid    = lvalid_q;
    assign ld_rdata    = ldata_q;
    assign mem_addr    = addr_q;
    assign mem_we      = we_q;
    assign mem_wdata   = wdata_q;
    assign halted      = halted_q;
endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: directed table, hand sequences and randomized model check of imem_port_arbiter.
module tb_imem_port_arbiter;
`ifdef IMEM_ARB_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif
    localparam int NR = 1500;
    logic clk, reset_n, fetch_req, fetch_gnt, fetch_valid, ld_req, ld_we, ld_gnt, ld_valid, mem_we, halted;
    logic [9:0] fetch_addr, fetch_data, ld_addr, ld_wdata, ld_rdata, mem_addr, mem_wdata, mem_rdata;
    logic bk_we;
    logic [9:0] bk_addr, bk_data;
    logic [9:0] mem [1024];
    int vectors = 0, miscompares = 0;

    imem_port_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_valid(ld_valid), .ld_rdata(ld_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory array: combinational read, write at the clock edge; backdoor port for preloading.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        else if (bk_we) mem[bk_addr] <= bk_data;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic poke(input int a, input logic [9:0] d);
        bk_we = 1'b1; bk_addr = a[9:0]; bk_data = d;
        @(posedge clk); #1;
        bk_we = 1'b0;
    endtask

    task automatic wait_gnt(input bit is_ld, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (is_ld ? ld_gnt : fetch_gnt) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_fgnt"}, fetch_gnt, 0);
        chk({tag, "_lgnt"}, ld_gnt, 0);
        chk({tag, "_fvalid"}, fetch_valid, 0);
        chk({tag, "_lvalid"}, ld_valid, 0);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_maddr"}, mem_addr, 0);
        chk({tag, "_mwdata"}, mem_wdata, 0);
        chk({tag, "_fdata"}, fetch_data, 0);
        chk({tag, "_ldata"}, ld_rdata, 0);
        chk({tag, "_halted"}, halted, 0);
    endtask

    // One directed cycle: inputs driven in the cycle and the outputs expected in it.
    typedef struct {
        logic fr; logic [9:0] fa; logic lr, lw; logic [9:0] la, lwd;
        logic fg, lg, fv, lv, we; logic [9:0] ma, fd; logic lc; logic [9:0] ld;
    } vec_t;

    function automatic vec_t v(input int fr, fa, lr, lw, la, lwd, fg, lg, fv, lv, we, ma, fd, lc, ld);
        vec_t r;
        r.fr = fr[0]; r.fa = fa[9:0]; r.lr = lr[0]; r.lw = lw[0]; r.la = la[9:0]; r.lwd = lwd[9:0];
        r.fg = fg[0]; r.lg = lg[0]; r.fv = fv[0]; r.lv = lv[0]; r.we = we[0];
        r.ma = ma[9:0]; r.fd = fd[9:0]; r.lc = lc[0]; r.ld = ld[9:0];
        return r;
    endfunction

    // Reference model state for the randomized run.
    logic [9:0] ref_mem [16];
    logic e_fg [NR+3], e_lg [NR+3], e_fv [NR+3], e_lv [NR+3], e_we [NR+3], e_lc [NR+3];
    logic [9:0] e_ma [NR+3], p_fd [NR+3], p_ld [NR+3];
    int m_free, halt_at;
    logic m_last_ld, m_halted, halt_val;
    logic [9:0] m_fd;

    // Arbiter behaviour at transaction level: a request seen while free is granted
    // next cycle, answered the cycle after, and the port is free again on that answer.
    task automatic model_step(input int n);
        logic fel, win_ld;
        logic [9:0] d;
        if (e_fv[n]) m_fd = p_fd[n];
        if (halt_at == n) m_halted = halt_val;
        fel = fetch_req && !m_halted;
        if (n >= m_free && (fel || ld_req)) begin
            win_ld = ld_req && (!fel || !m_last_ld);
            m_last_ld = win_ld;
            m_free = n + 2;
            if (win_ld) begin
                e_lg[n+1] = 1'b1; e_ma[n+1] = ld_addr; e_we[n+1] = ld_we; e_lv[n+2] = 1'b1;
                if (ld_we) begin
                    ref_mem[ld_addr[3:0]] = ld_wdata;
                    if (HALT_EN) begin halt_at = n + 2; halt_val = 1'b0; end
                end else begin
                    e_lc[n+2] = 1'b1; p_ld[n+2] = ref_mem[ld_addr[3:0]];
                end
            end else begin
                d = ref_mem[fetch_addr[3:0]];
                e_fg[n+1] = 1'b1; e_ma[n+1] = fetch_addr; e_fv[n+2] = 1'b1; p_fd[n+2] = d;
                if (HALT_EN && d[9:7] == 3'b111) begin halt_at = n + 2; halt_val = 1'b1; end
            end
        end
    endtask

    initial begin
        vec_t tv [18];
        bit ok, g_f, g_l;
        int cnt;
        logic [31:0] r;
        bk_we = 1'b0; bk_addr = '0; bk_data = '0;
        fetch_addr = '0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
        // T1: reset held with both requests up.
        reset_n = 1'b0; fetch_req = 1'b1; ld_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk_zero($sformatf("t1_rst%0d", i));
        end
        @(posedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_first_fgnt", fetch_gnt, 1);
        chk("t1_first_lgnt", ld_gnt, 0);
        fetch_req = 1'b0; ld_req = 1'b0;

        // T3 contention, T2 single fetch, T4 write then read.
        tv[0]  = v(1,1,1,0,0,0,     0,0,0,0,0, 0,'h000,0,0);
        tv[1]  = v(1,1,1,0,0,0,     1,0,0,0,0, 1,'h000,0,0);
        tv[2]  = v(1,1,1,0,0,0,     0,0,1,0,0, 0,'h155,0,0);
        tv[3]  = v(1,1,1,0,0,0,     0,1,0,0,0, 0,'h155,0,0);
        tv[4]  = v(1,1,1,0,0,0,     0,0,0,1,0, 0,'h155,1,'h09E);
        tv[5]  = v(1,1,1,0,0,0,     1,0,0,0,0, 1,'h155,0,0);
        tv[6]  = v(1,1,1,0,0,0,     0,0,1,0,0, 0,'h155,0,0);
        tv[7]  = v(0,0,0,0,0,0,     0,1,0,0,0, 0,'h155,0,0);
        tv[8]  = v(0,0,0,0,0,0,     0,0,0,1,0, 0,'h155,1,'h09E);
        tv[9]  = v(1,0,0,0,0,0,     0,0,0,0,0, 0,'h155,0,0);
        tv[10] = v(1,0,0,0,0,0,     1,0,0,0,0, 0,'h155,0,0);
        tv[11] = v(0,0,0,0,0,0,     0,0,1,0,0, 0,'h09E,0,0);
        tv[12] = v(0,0,1,1,5,'h3FF, 0,0,0,0,0, 0,'h09E,0,0);
        tv[13] = v(0,0,1,1,5,'h3FF, 0,1,0,0,1, 5,'h09E,0,0);
        tv[14] = v(1,5,0,0,0,0,     0,0,0,1,0, 0,'h09E,0,0);
        tv[15] = v(1,5,0,0,0,0,     1,0,0,0,0, 5,'h09E,0,0);
        tv[16] = v(0,0,0,0,0,0,     0,0,1,0,0, 0,'h3FF,0,0);
        tv[17] = v(0,0,0,0,0,0,     0,0,0,0,0, 0,'h3FF,0,0);
        reset_n = 1'b0;
        poke(0, 10'b0010011110); poke(1, 10'h155); poke(5, 10'h000);
        @(posedge clk); #1 reset_n = 1'b1;
        for (int i = 0; i < 18; i++) begin
            fetch_req = tv[i].fr; fetch_addr = tv[i].fa;
            ld_req = tv[i].lr; ld_we = tv[i].lw; ld_addr = tv[i].la; ld_wdata = tv[i].lwd;
            @(negedge clk);
            chk($sformatf("tv%0d_fgnt", i), fetch_gnt, tv[i].fg);
            chk($sformatf("tv%0d_lgnt", i), ld_gnt, tv[i].lg);
            chk($sformatf("tv%0d_fvalid", i), fetch_valid, tv[i].fv);
            chk($sformatf("tv%0d_lvalid", i), ld_valid, tv[i].lv);
            chk($sformatf("tv%0d_we", i), mem_we, tv[i].we);
            chk($sformatf("tv%0d_fdata", i), fetch_data, tv[i].fd);
            chk($sformatf("tv%0d_halted", i), halted, 0);
            if (tv[i].fg || tv[i].lg) chk($sformatf("tv%0d_maddr", i), mem_addr, tv[i].ma);
            if (tv[i].lc) chk($sformatf("tv%0d_ldata", i), ld_rdata, tv[i].ld);
            @(posedge clk); #1;
        end

        // T5: halt instruction fetch, blocked fetch, loader write clears halt.
        fetch_req = 1'b0; ld_req = 1'b0; reset_n = 1'b0;
        poke(27, 10'b1110000000); poke(0, 10'h000);
        @(posedge clk); #1 reset_n = 1'b1;
        fetch_req = 1'b1; fetch_addr = 10'd27;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5_halt_fgnt", fetch_gnt, 1);
        @(posedge clk); #1 fetch_req = 1'b0;
        @(negedge clk);
        chk("t5_halt_fvalid", fetch_valid, 1);
        chk("t5_halt_fdata", fetch_data, 10'h380);
        chk("t5_halted", halted, HALT_EN);
        fetch_req = 1'b1; fetch_addr = 10'd0;
        cnt = 0;
        repeat (10) begin
            @(posedge clk); #1;
            @(negedge clk);
            cnt += int'(fetch_gnt);
        end
        chk("t5_blocked_gnts", cnt, HALT_EN ? 0 : 5);
        @(posedge clk); #1;
        fetch_req = 1'b0; ld_req = 1'b1; ld_we = 1'b1; ld_addr = 10'd0; ld_wdata = 10'h055;
        wait_gnt(1'b1, ok);
        chk("t5_ld_gnt_seen", ok, 1);
        @(posedge clk); #1 ld_req = 1'b0;
        @(negedge clk);
        chk("t5_ld_valid", ld_valid, 1);
        chk("t5_halt_cleared", halted, 0);
        @(posedge clk); #1 fetch_req = 1'b1; fetch_addr = 10'd0;
        wait_gnt(1'b0, ok);
        chk("t5_refetch_gnt_seen", ok, 1);
        @(posedge clk); #1 fetch_req = 1'b0;
        @(negedge clk);
        chk("t5_refetch_valid", fetch_valid, 1);
        chk("t5_refetch_data", fetch_data, 10'h055);

        // T6: reset during a loader-write access.
        @(posedge clk); #1;
        poke(9, 10'h000);
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 10'd9; ld_wdata = 10'h2AA;
        wait_gnt(1'b1, ok);
        chk("t6_gnt_seen", ok, 1);
        chk("t6_we_in_access", mem_we, 1);
        reset_n = 1'b0;
        @(posedge clk); #1 ld_req = 1'b0;
        @(negedge clk);
        chk("t6_we_after", mem_we, 0);
        chk("t6_no_lvalid", ld_valid, 0);
        chk("t6_no_lgnt", ld_gnt, 0);
        chk("t6_no_fvalid", fetch_valid, 0);
        chk("t6_mem_written", mem[9], 10'h2AA);

        // Randomized run against the transaction-level model.
        fetch_req = 1'b0; ld_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            r = $urandom;
            poke(i, r[9:0]);
            ref_mem[i] = r[9:0];
        end
        for (int i = 0; i < NR + 3; i++) begin
            e_fg[i] = 0; e_lg[i] = 0; e_fv[i] = 0; e_lv[i] = 0; e_we[i] = 0; e_lc[i] = 0;
            e_ma[i] = '0; p_fd[i] = '0; p_ld[i] = '0;
        end
        m_free = 0; halt_at = -1; m_last_ld = 1'b1; m_halted = 1'b0; halt_val = 1'b0; m_fd = '0;
        g_f = 1'b0; g_l = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        for (int n = 0; n < NR; n++) begin
            if (!fetch_req || g_f) begin
                r = $urandom;
                fetch_req = r[1:0] != 2'b00;
                fetch_addr = {6'd0, r[5:2]};
            end
            if (!ld_req || g_l) begin
                r = $urandom;
                ld_req = r[1:0] != 2'b00;
                ld_we = r[2];
                ld_addr = {6'd0, r[6:3]};
                ld_wdata = r[16:7];
            end
            @(negedge clk);
            model_step(n);
            chk($sformatf("rnd%0d_fgnt", n), fetch_gnt, e_fg[n]);
            chk($sformatf("rnd%0d_lgnt", n), ld_gnt, e_lg[n]);
            chk($sformatf("rnd%0d_fvalid", n), fetch_valid, e_fv[n]);
            chk($sformatf("rnd%0d_lvalid", n), ld_valid, e_lv[n]);
            chk($sformatf("rnd%0d_we", n), mem_we, e_we[n]);
            chk($sformatf("rnd%0d_halted", n), halted, m_halted);
            chk($sformatf("rnd%0d_fdata", n), fetch_data, m_fd);
            if (e_fg[n] || e_lg[n]) chk($sformatf("rnd%0d_maddr", n), mem_addr, e_ma[n]);
            if (e_lc[n]) chk($sformatf("rnd%0d_ldata", n), ld_rdata, p_ld[n]);
            g_f = fetch_gnt; g_l = ld_gnt;
            @(posedge clk); #1;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
